// File: rtl/bsg_wormhole_concentrator_out_demux_pkg.sv
// Shared FSM encodings and header field offsets for the concentrator output demux.
// Header layout, LSB first: cord, len, cid.
package bsg_wormhole_concentrator_out_demux_pkg;

  localparam logic [0:0] state_hdr  = 1'b0;
  localparam logic [0:0] state_body = 1'b1;

  function automatic int len_offset(int cord_width);
    return cord_width;
  endfunction

  function automatic int cid_offset(int cord_width, int len_width);
    return cord_width + len_width;
  endfunction

endpackage

// File: rtl/bsg_wormhole_concentrator_out_demux_if.sv
// Concentrated input link plus the fanned-out per-lane output links.
// The slave modport is the demux; the master modport is whatever feeds it and drains the lanes.
interface bsg_wormhole_concentrator_out_demux_if #(
  parameter int flit_width_p = 32,
  parameter int num_out_p    = 2
);
  logic                              concentrated_link_v;
  logic [flit_width_p-1:0]           concentrated_link_data;
  logic                              concentrated_link_ready_and_rev;
  logic [num_out_p-1:0]              links_v;
  logic [num_out_p*flit_width_p-1:0] links_data;
  logic [num_out_p-1:0]              links_ready_and_rev;

  modport slave (
    input  concentrated_link_v, concentrated_link_data, links_ready_and_rev,
    output concentrated_link_ready_and_rev, links_v, links_data
  );

  modport master (
    output concentrated_link_v, concentrated_link_data, links_ready_and_rev,
    input  concentrated_link_ready_and_rev, links_v, links_data
  );
endinterface

// File: rtl/bsg_wormhole_concentrator_out_demux_ctrl.sv
// Packet steering control: HDR/BODY FSM, body-flit counter, lane select and sticky bad-cid flag.
//   state      | meaning
//   state_hdr  | buffer head is a header; route by its cid or drop it
//   state_body | forwarding (or dropping) body flits of the current packet
module bsg_wormhole_concentrator_out_demux_ctrl
  import bsg_wormhole_concentrator_out_demux_pkg::*;
#(
  parameter int len_width_p = 4,
  parameter int cid_width_p = 2,
  parameter int num_out_p   = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   head_v,
  input  logic [cid_width_p-1:0] hdr_cid,
  input  logic [len_width_p-1:0] hdr_len,
  input  logic [num_out_p-1:0]   links_ready,
  output logic [num_out_p-1:0]   links_v,
  output logic                   pop,
  output logic                   bad_cid
);
  localparam logic [num_out_p-1:0] one_lp = num_out_p'(1);

  logic [0:0]             state;
  logic                   drop;
  logic [cid_width_p-1:0] sel;
  logic [len_width_p-1:0] cnt;
  logic                   hdr_ok;
  logic                   drop_now;
  logic [cid_width_p-1:0] lane;
  logic [num_out_p-1:0]   onehot;

  assign hdr_ok = (int'(hdr_cid) < num_out_p);

  // Valid depends only on state and buffer head, never on lane ready.
  always_comb begin
    lane     = sel;
    drop_now = drop;
    if (state == state_hdr) begin
      lane     = hdr_cid;
      drop_now = ~hdr_ok;
    end
    onehot  = one_lp << lane;
    links_v = '0;
    if (head_v && !drop_now) links_v = onehot;
    pop = head_v & (drop_now | (|(onehot & links_ready)));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= state_hdr;
      drop    <= 1'b0;
      sel     <= '0;
      cnt     <= '0;
      bad_cid <= 1'b0;
    end else if (pop) begin
      if (state == state_hdr) begin
        sel   <= hdr_cid;
        cnt   <= hdr_len;
        drop  <= ~hdr_ok;
        state <= (hdr_len != '0) ? state_body : state_hdr;
        if (!hdr_ok) bad_cid <= 1'b1;
      end else begin
        cnt <= cnt - len_width_p'(1);
        if (cnt == len_width_p'(1)) state <= state_hdr;
      end
    end
  end

endmodule

// File: rtl/bsg_wormhole_concentrator_out_demux.sv
// Wormhole concentrator output demux: 2-entry input buffer feeding per-lane outputs,
// whole packets steered by the header cid; out-of-range cids are dropped and flagged.
module bsg_wormhole_concentrator_out_demux
  import bsg_wormhole_concentrator_out_demux_pkg::*;
#(
  parameter int flit_width_p = 32,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 2,
  parameter int cord_width_p = 5,
  parameter int num_out_p    = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_wormhole_concentrator_out_demux_if.slave link,
  output logic bad_cid_o
);
  localparam int len_lsb_lp = len_offset(cord_width_p);
  localparam int cid_lsb_lp = cid_offset(cord_width_p, len_width_p);

  logic [flit_width_p-1:0] mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic                    full;
  logic                    head_v;
  logic                    push;
  logic                    pop;
  logic [flit_width_p-1:0] head;
  logic [num_out_p-1:0]    lane_v;

  assign full   = (count == 2'd2);
  assign head_v = (count != 2'd0);
  assign head   = mem[rd_ptr];

  // Ready is held low during reset so nothing is accepted into a buffer being cleared.
  assign link.concentrated_link_ready_and_rev = reset_n_i & ~full;
  assign push = link.concentrated_link_v & link.concentrated_link_ready_and_rev;

  assign link.links_data = {num_out_p{head}};
  assign link.links_v    = lane_v;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= link.concentrated_link_data;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  bsg_wormhole_concentrator_out_demux_ctrl #(
    .len_width_p(len_width_p),
    .cid_width_p(cid_width_p),
    .num_out_p  (num_out_p)
  ) ctrl (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .head_v     (head_v),
    .hdr_cid    (head[cid_lsb_lp +: cid_width_p]),
    .hdr_len    (head[len_lsb_lp +: len_width_p]),
    .links_ready(link.links_ready_and_rev),
    .links_v    (lane_v),
    .pop        (pop),
    .bad_cid    (bad_cid_o)
  );

endmodule

// File: tb/tb_bsg_wormhole_concentrator_out_demux.sv
// Directed bench for the concentrator output demux: one DUT with 4 lanes and a
// second with 3 lanes so that cid=3 is out of range.
module tb_bsg_wormhole_concentrator_out_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bad_a, bad_b;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  bsg_wormhole_concentrator_out_demux_if #(.flit_width_p(32), .num_out_p(4)) if_a ();
  bsg_wormhole_concentrator_out_demux_if #(.flit_width_p(32), .num_out_p(3)) if_b ();

  bsg_wormhole_concentrator_out_demux #(
    .flit_width_p(32), .len_width_p(4), .cid_width_p(2), .cord_width_p(5), .num_out_p(4)
  ) dut_a (.clk_i(clk), .reset_n_i(rst_n), .link(if_a), .bad_cid_o(bad_a));

  bsg_wormhole_concentrator_out_demux #(
    .flit_width_p(32), .len_width_p(4), .cid_width_p(2), .cord_width_p(5), .num_out_p(3)
  ) dut_b (.clk_i(clk), .reset_n_i(rst_n), .link(if_b), .bad_cid_o(bad_b));

  typedef struct {
    int          c;
    int          lane;
    logic [31:0] data;
  } fire_t;

  fire_t      log_a[$];
  fire_t      log_b[$];
  bit         multi_hot = 0;
  logic [3:0] vseen_a = '0;
  logic [2:0] vseen_b = '0;
  int         bad_first_b = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int l = 0; l < 4; l++)
      if (if_a.links_v[l] && if_a.links_ready_and_rev[l])
        log_a.push_back('{cyc, l, if_a.links_data[l*32 +: 32]});
    for (int l = 0; l < 3; l++)
      if (if_b.links_v[l] && if_b.links_ready_and_rev[l])
        log_b.push_back('{cyc, l, if_b.links_data[l*32 +: 32]});
    if ($countones(if_a.links_v) > 1 || $countones(if_b.links_v) > 1) multi_hot = 1;
    vseen_a = vseen_a | if_a.links_v;
    vseen_b = vseen_b | if_b.links_v;
    if (bad_b && bad_first_b < 0) bad_first_b = cyc;
  end

  function automatic logic [31:0] hdr(input int cid, input int len, input logic [15:0] tag);
    logic [1:0] c2;
    logic [3:0] l4;
    c2 = cid[1:0];
    l4 = len[3:0];
    return {tag, 5'b0, c2, l4, 5'd7};
  endfunction

  task automatic push(input bit to_b, input logic [31:0] d, output int acc_cyc);
    bit acc = 0;
    int guard = 0;
    acc_cyc = -1;
    if (to_b) begin if_b.concentrated_link_v = 1'b1; if_b.concentrated_link_data = d; end
    else      begin if_a.concentrated_link_v = 1'b1; if_a.concentrated_link_data = d; end
    while (!acc && guard < 200) begin
      @(negedge clk); #1;
      acc = to_b ? if_b.concentrated_link_ready_and_rev : if_a.concentrated_link_ready_and_rev;
      acc_cyc = cyc;
      @(posedge clk); #1;
      guard++;
    end
    if (to_b) if_b.concentrated_link_v = 1'b0;
    else      if_a.concentrated_link_v = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL push_timeout: flit %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic test_reset;
    if_a.concentrated_link_v = 0; if_a.concentrated_link_data = '0; if_a.links_ready_and_rev = 4'hF;
    if_b.concentrated_link_v = 0; if_b.concentrated_link_data = '0; if_b.links_ready_and_rev = 3'h7;
    rst_n = 0;
    #12;
    tests++; if (if_a.links_v !== 4'b0) begin fails++; $display("FAIL rst_links_v_a: got %b want 0000", if_a.links_v); end
    tests++; if (if_a.concentrated_link_ready_and_rev !== 1'b0) begin fails++; $display("FAIL rst_ready_a: got %b want 0", if_a.concentrated_link_ready_and_rev); end
    tests++; if (if_b.concentrated_link_ready_and_rev !== 1'b0) begin fails++; $display("FAIL rst_ready_b: got %b want 0", if_b.concentrated_link_ready_and_rev); end
    tests++; if (bad_a !== 1'b0 || bad_b !== 1'b0) begin fails++; $display("FAIL rst_bad: got %b%b want 00", bad_a, bad_b); end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    tests++; if (if_a.concentrated_link_ready_and_rev !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", if_a.concentrated_link_ready_and_rev); end
    tests++; if (if_a.links_v !== 4'b0) begin fails++; $display("FAIL post_rst_idle: got %b want 0000", if_a.links_v); end
  endtask

  task automatic test_single;
    logic [31:0] exp [4];
    int a0, a;
    exp = '{hdr(2, 3, 16'h1001), 32'hB0D1_0001, 32'hB0D1_0002, 32'hB0D1_0003};
    log_a.delete(); vseen_a = '0;
    push(0, exp[0], a0);
    for (int i = 1; i < 4; i++) push(0, exp[i], a);
    repeat (3) @(posedge clk); #1;
    tests++; if (log_a.size() !== 4) begin fails++; $display("FAIL single_count: got %0d want 4", log_a.size()); end
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      tests++;
      if (log_a[i].lane !== 2 || log_a[i].data !== exp[i] || log_a[i].c !== a0 + 1 + i) begin
        fails++;
        $display("FAIL single_flit%0d: got lane %0d data %h cyc %0d want lane 2 data %h cyc %0d",
                 i, log_a[i].lane, log_a[i].data, log_a[i].c, exp[i], a0 + 1 + i);
      end
    end
    tests++; if ((vseen_a & 4'b1011) !== 4'b0) begin fails++; $display("FAIL single_other_lanes: got %b want x0xx=0", vseen_a); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [4];
    int lanes [4];
    int a0, a;
    exp   = '{hdr(1, 0, 16'h2001), hdr(3, 2, 16'h2002), 32'hB0D2_0001, 32'hB0D2_0002};
    lanes = '{1, 3, 3, 3};
    log_a.delete();
    push(0, exp[0], a0);
    for (int i = 1; i < 4; i++) push(0, exp[i], a);
    repeat (3) @(posedge clk); #1;
    tests++; if (log_a.size() !== 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", log_a.size()); end
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      tests++;
      if (log_a[i].lane !== lanes[i] || log_a[i].data !== exp[i] || log_a[i].c !== a0 + 1 + i) begin
        fails++;
        $display("FAIL b2b_flit%0d: got lane %0d data %h cyc %0d want lane %0d data %h cyc %0d",
                 i, log_a[i].lane, log_a[i].data, log_a[i].c, lanes[i], exp[i], a0 + 1 + i);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [6];
    bit low_seen = 0;
    bit armed = 0;
    exp = '{hdr(0, 5, 16'h3001), 32'hB0D3_0001, 32'hB0D3_0002, 32'hB0D3_0003, 32'hB0D3_0004, 32'hB0D3_0005};
    log_a.delete();
    fork
      begin
        int a;
        for (int i = 0; i < 6; i++) push(0, exp[i], a);
      end
      begin
        for (int g = 0; g < 50 && !armed; g++) begin
          @(posedge clk); #1;
          if (log_a.size() >= 2) armed = 1;
        end
        if_a.links_ready_and_rev[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          if (!if_a.concentrated_link_ready_and_rev) low_seen = 1;
        end
        @(posedge clk); #1;
        if_a.links_ready_and_rev[0] = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    tests++; if (!armed) begin fails++; $display("FAIL bp_arm: got %0d lane-0 flits want >=2 before stall", log_a.size()); end
    tests++; if (!low_seen) begin fails++; $display("FAIL bp_ready_low: got ready stuck 1 want 0 during stall"); end
    tests++; if (log_a.size() !== 6) begin fails++; $display("FAIL bp_count: got %0d want 6", log_a.size()); end
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      tests++;
      if (log_a[i].lane !== 0 || log_a[i].data !== exp[i]) begin
        fails++;
        $display("FAIL bp_flit%0d: got lane %0d data %h want lane 0 data %h", i, log_a[i].lane, log_a[i].data, exp[i]);
      end
    end
  endtask

  task automatic test_bad_cid;
    logic [31:0] good;
    int a0, a, a3;
    good = hdr(0, 0, 16'h4002);
    log_b.delete(); vseen_b = '0; bad_first_b = -1;
    tests++; if (bad_b !== 1'b0) begin fails++; $display("FAIL bad_pre: got %b want 0", bad_b); end
    push(1, hdr(3, 2, 16'h4001), a0);
    push(1, 32'hB0D4_0001, a);
    push(1, 32'hB0D4_0002, a);
    push(1, good, a3);
    repeat (4) @(posedge clk); #1;
    tests++; if (bad_first_b !== a0 + 2) begin fails++; $display("FAIL bad_timing: got first cycle %0d want %0d", bad_first_b, a0 + 2); end
    tests++; if (bad_b !== 1'b1) begin fails++; $display("FAIL bad_sticky: got %b want 1", bad_b); end
    tests++; if (log_b.size() !== 1) begin fails++; $display("FAIL bad_drop_count: got %0d want 1", log_b.size()); end
    if (log_b.size() > 0) begin
      tests++;
      if (log_b[0].lane !== 0 || log_b[0].data !== good || log_b[0].c !== a0 + 4) begin
        fails++;
        $display("FAIL bad_next_pkt: got lane %0d data %h cyc %0d want lane 0 data %h cyc %0d",
                 log_b[0].lane, log_b[0].data, log_b[0].c, good, a0 + 4);
      end
    end
    tests++; if (vseen_b !== 3'b001) begin fails++; $display("FAIL bad_lanes: got %b want 001", vseen_b); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] h;
    int a;
    h = hdr(2, 0, 16'h5002);
    push(0, hdr(1, 5, 16'h5001), a);
    push(0, 32'hB0D5_0001, a);
    push(0, 32'hB0D5_0002, a);
    if_a.concentrated_link_v = 1'b1; if_a.concentrated_link_data = 32'hB0D5_0003;
    #3 rst_n = 0;
    #1;
    tests++; if (if_a.links_v !== 4'b0) begin fails++; $display("FAIL mrst_links_v: got %b want 0000", if_a.links_v); end
    tests++; if (if_a.concentrated_link_ready_and_rev !== 1'b0) begin fails++; $display("FAIL mrst_ready: got %b want 0", if_a.concentrated_link_ready_and_rev); end
    if_a.concentrated_link_v = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    log_a.delete(); vseen_a = '0;
    push(0, h, a);
    repeat (3) @(posedge clk); #1;
    tests++; if (log_a.size() !== 1) begin fails++; $display("FAIL mrst_count: got %0d want 1", log_a.size()); end
    if (log_a.size() > 0) begin
      tests++;
      if (log_a[0].lane !== 2 || log_a[0].data !== h || log_a[0].c !== a + 1) begin
        fails++;
        $display("FAIL mrst_route: got lane %0d data %h cyc %0d want lane 2 data %h cyc %0d",
                 log_a[0].lane, log_a[0].data, log_a[0].c, h, a + 1);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_q [4][$];
    logic [31:0] got_q [4][$];
    bit done = 0;
    int t_end;
    log_a.delete(); multi_hot = 0;
    t_end = cyc + 10000;
    fork
      begin
        int a, cid, len;
        logic [15:0] id = 16'h0;
        while (cyc < t_end) begin
          logic [31:0] f;
          cid = $urandom_range(0, 3);
          len = ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 3);
          id  = id + 16'd1;
          f = hdr(cid, len, id);
          exp_q[cid].push_back(f);
          push(0, f, a);
          for (int i = 0; i < len; i++) begin
            f = {id, 8'hBB, 8'(i)};
            exp_q[cid].push_back(f);
            push(0, f, a);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if_a.links_ready_and_rev = 4'($urandom_range(0, 15));
        end
      end
    join
    if_a.links_ready_and_rev = 4'hF;
    repeat (40) @(posedge clk); #1;
    foreach (log_a[i]) got_q[log_a[i].lane].push_back(log_a[i].data);
    for (int l = 0; l < 4; l++) begin
      int bad_at = -1;
      tests++;
      for (int i = 0; i < exp_q[l].size() && i < got_q[l].size(); i++)
        if (bad_at < 0 && got_q[l][i] !== exp_q[l][i]) bad_at = i;
      if (got_q[l].size() !== exp_q[l].size() || bad_at >= 0) begin
        fails++;
        $display("FAIL rand_lane%0d: got %0d flits (first diff at %0d) want %0d flits",
                 l, got_q[l].size(), bad_at, exp_q[l].size());
      end
    end
    tests++; if (multi_hot) begin fails++; $display("FAIL onehot: got multiple links_v bits high want at most one"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bad_cid();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
